// File: rtl/neighbor_table_update_pkg.sv
// Shared network-layer definitions for the neighbor table.
// Holds table base addresses, the neighborCount word address, the table capacity default,
// the update FSM state encoding and a slot-to-address helper.
package neighbor_table_update_pkg;

  localparam int unsigned MaxNeighborsDefault = 64;
  localparam logic [15:0] AddrNcountDefault   = 16'h068A;

  // Word arrays, one 16-bit word per entry, byte addressed
  localparam logic [15:0] BaseNeighborId = 16'h0048;
  localparam logic [15:0] BaseClusterId  = 16'h00C8;
  localparam logic [15:0] BaseBattery    = 16'h0148;
  localparam logic [15:0] BaseQValue     = 16'h01C8;

  typedef enum logic [3:0] {
    StIdle,
    StLdCnt,
    StScan,
    StWrCid,
    StWrBat,
    StWrQv,
    StWrId,
    StWrCnt,
    StDone
  } state_e;

  // Byte address of word `slot` in the array starting at `base`
  function automatic logic [15:0] entry_addr(input logic [15:0] base, input logic [15:0] slot);
    return base + {slot[14:0], 1'b0};
  endfunction

endpackage

// File: rtl/neighbor_table_update.sv
// Merges one received neighbor packet into the memory-resident neighbor table.
// Reads neighborCount, scans neighborID entries for the sender, then either rewrites the
// sender's clusterID/batteryStat/qValue words in place or appends a new entry and bumps
// neighborCount. A full table drops the update.
//
// Ports:
//   clock, nrst          rising-edge clock, synchronous active-low reset
//   start                request one update (sampled only when idle)
//   pkt_src_id/cluster_id/battery/qvalue   packet fields, latched on start
//   data_in              memory read data for the current address
//   address, wr_en, data_out   registered memory port
//   index                slot written by the last update
//   new_entry            last update appended a neighbor
//   table_full           last update was dropped (table full)
//   done                 update complete, held until start falls
module neighbor_table_update
  import neighbor_table_update_pkg::*;
#(
  parameter int unsigned MAX_NEIGHBORS = MaxNeighborsDefault,
  parameter logic [15:0] ADDR_NCOUNT   = AddrNcountDefault
) (
  input  logic        clock,
  input  logic        nrst,
  input  logic        start,
  input  logic [15:0] pkt_src_id,
  input  logic [15:0] pkt_cluster_id,
  input  logic [15:0] pkt_battery,
  input  logic [15:0] pkt_qvalue,
  input  logic [15:0] data_in,
  output logic [15:0] address,
  output logic        wr_en,
  output logic [15:0] data_out,
  output logic [15:0] index,
  output logic        new_entry,
  output logic        table_full,
  output logic        done
);

  localparam logic [15:0] MaxCnt = 16'(MAX_NEIGHBORS);

  state_e      state_q, state_d;
  logic [15:0] src_q, src_d, cid_q, cid_d, bat_q, bat_d, qv_q, qv_d;
  logic [15:0] i_q, i_d, count_q, count_d, index_q, index_d;
  logic [15:0] address_q, address_d, data_out_q, data_out_d;
  logic        new_entry_q, new_entry_d, table_full_q, table_full_d;
  logic        done_q, done_d, wr_en_q, wr_en_d;

  logic        take_append, write_start;
  logic [15:0] append_cnt, write_slot, cnt_clamped, i_next;

  assign cnt_clamped = (data_in > MaxCnt) ? MaxCnt : data_in;
  assign i_next      = i_q + 16'd1;

  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    cid_d        = cid_q;
    bat_d        = bat_q;
    qv_d         = qv_q;
    i_d          = i_q;
    count_d      = count_q;
    index_d      = index_q;
    new_entry_d  = new_entry_q;
    table_full_d = table_full_q;
    done_d       = done_q;
    address_d    = address_q;
    data_out_d   = data_out_q;
    wr_en_d      = 1'b0;
    take_append  = 1'b0;
    append_cnt   = count_q;
    write_start  = 1'b0;
    write_slot   = index_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          src_d        = pkt_src_id;
          cid_d        = pkt_cluster_id;
          bat_d        = pkt_battery;
          qv_d         = pkt_qvalue;
          address_d    = ADDR_NCOUNT;
          index_d      = 16'd0;
          new_entry_d  = 1'b0;
          table_full_d = 1'b0;
          i_d          = 16'd0;
          state_d      = StLdCnt;
        end
      end
      StLdCnt: begin
        count_d = cnt_clamped;
        if (cnt_clamped == 16'd0) begin
          take_append = 1'b1;
          append_cnt  = cnt_clamped;
        end else begin
          address_d = BaseNeighborId;
          i_d       = 16'd0;
          state_d   = StScan;
        end
      end
      StScan: begin
        if (data_in == src_q) begin
          index_d     = i_q;
          new_entry_d = 1'b0;
          write_start = 1'b1;
          write_slot  = i_q;
        end else if (i_next == count_q) begin
          take_append = 1'b1;
          append_cnt  = count_q;
        end else begin
          i_d       = i_next;
          address_d = entry_addr(BaseNeighborId, i_next);
        end
      end
      StWrCid: begin
        address_d  = entry_addr(BaseBattery, index_q);
        data_out_d = bat_q;
        wr_en_d    = 1'b1;
        state_d    = StWrBat;
      end
      StWrBat: begin
        address_d  = entry_addr(BaseQValue, index_q);
        data_out_d = qv_q;
        wr_en_d    = 1'b1;
        state_d    = StWrQv;
      end
      StWrQv: begin
        if (new_entry_q) begin
          address_d  = entry_addr(BaseNeighborId, index_q);
          data_out_d = src_q;
          wr_en_d    = 1'b1;
          state_d    = StWrId;
        end else begin
          done_d  = 1'b1;
          state_d = StDone;
        end
      end
      StWrId: begin
        address_d  = ADDR_NCOUNT;
        data_out_d = count_q + 16'd1;
        wr_en_d    = 1'b1;
        state_d    = StWrCnt;
      end
      StWrCnt: begin
        done_d  = 1'b1;
        state_d = StDone;
      end
      StDone: begin
        if (!start) begin
          done_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Sender not found (or empty table): append if there is room, else drop
    if (take_append) begin
      if (append_cnt >= MaxCnt) begin
        table_full_d = 1'b1;
        done_d       = 1'b1;
        state_d      = StDone;
      end else begin
        index_d     = append_cnt;
        new_entry_d = 1'b1;
        write_start = 1'b1;
        write_slot  = append_cnt;
      end
    end

    // First word of the write sequence is presented on the same edge the slot is chosen
    if (write_start) begin
      address_d  = entry_addr(BaseClusterId, write_slot);
      data_out_d = cid_q;
      wr_en_d    = 1'b1;
      state_d    = StWrCid;
    end
  end

  always_ff @(posedge clock) begin
    if (!nrst) begin
      state_q      <= StIdle;
      src_q        <= 16'd0;
      cid_q        <= 16'd0;
      bat_q        <= 16'd0;
      qv_q         <= 16'd0;
      i_q          <= 16'd0;
      count_q      <= 16'd0;
      index_q      <= 16'd0;
      new_entry_q  <= 1'b0;
      table_full_q <= 1'b0;
      done_q       <= 1'b0;
      address_q    <= ADDR_NCOUNT;
      data_out_q   <= 16'd0;
      wr_en_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      cid_q        <= cid_d;
      bat_q        <= bat_d;
      qv_q         <= qv_d;
      i_q          <= i_d;
      count_q      <= count_d;
      index_q      <= index_d;
      new_entry_q  <= new_entry_d;
      table_full_q <= table_full_d;
      done_q       <= done_d;
      address_q    <= address_d;
      data_out_q   <= data_out_d;
      wr_en_q      <= wr_en_d;
    end
  end

  assign address    = address_q;
  assign wr_en      = wr_en_q;
  assign data_out   = data_out_q;
  assign index      = index_q;
  assign new_entry  = new_entry_q;
  assign table_full = table_full_q;
  assign done       = done_q;

endmodule

// File: tb/tb_neighbor_table_update.sv
// Directed bench for neighbor_table_update with a word-addressed memory model.
module tb_neighbor_table_update;

  logic        clock = 1'b0;
  logic        nrst, start;
  logic [15:0] pkt_src_id, pkt_cluster_id, pkt_battery, pkt_qvalue, data_in;
  logic [15:0] address, data_out, index;
  logic        wr_en, new_entry, table_full, done;

  logic [15:0] mem [0:1023];
  logic        pre_clr = 1'b0, pre_we = 1'b0;
  logic [15:0] pre_addr = 16'h0, pre_data = 16'h0;
  logic [15:0] wa [0:255];
  logic [15:0] wd [0:255];
  int          wn = 0;
  int          vec = 0, err = 0;

  always #5 clock = ~clock;

  neighbor_table_update dut (
    .clock          (clock),
    .nrst           (nrst),
    .start          (start),
    .pkt_src_id     (pkt_src_id),
    .pkt_cluster_id (pkt_cluster_id),
    .pkt_battery    (pkt_battery),
    .pkt_qvalue     (pkt_qvalue),
    .data_in        (data_in),
    .address        (address),
    .wr_en          (wr_en),
    .data_out       (data_out),
    .index          (index),
    .new_entry      (new_entry),
    .table_full     (table_full),
    .done           (done)
  );

  assign data_in = mem[address[10:1]];

  // Memory model plus a log of every write strobe the DUT issues
  always @(posedge clock) begin
    if (pre_clr) begin
      for (int k = 0; k < 1024; k++) mem[k] <= 16'h0;
    end else if (pre_we) begin
      mem[pre_addr[10:1]] <= pre_data;
    end
    if (wr_en) begin
      mem[address[10:1]] <= data_out;
      wa[wn[7:0]] <= address;
      wd[wn[7:0]] <= data_out;
      wn <= wn + 1;
    end
  end

  task automatic mem_clear();
    @(negedge clock); pre_clr = 1'b1;
    @(negedge clock); pre_clr = 1'b0;
  endtask

  task automatic mem_write(input logic [15:0] a, input logic [15:0] d);
    @(negedge clock); pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock); pre_we = 1'b0;
  endtask

  // Raise start, scramble packet inputs after they are sampled, return edges until done
  task automatic run_update(input logic [15:0] s, input logic [15:0] c, input logic [15:0] b,
                            input logic [15:0] q, output int lat, output int n0);
    @(negedge clock);
    pkt_src_id = s; pkt_cluster_id = c; pkt_battery = b; pkt_qvalue = q;
    start = 1'b1;
    n0 = wn;
    @(posedge clock);
    #1;
    pkt_src_id = 16'hDEAD; pkt_cluster_id = 16'hDEAD; pkt_battery = 16'hDEAD;
    pkt_qvalue = 16'hDEAD;
    lat = -1;
    for (int e = 1; e <= 100; e++) begin
      @(posedge clock); #1;
      if (done) begin lat = e; break; end
    end
  endtask

  task automatic drop_start();
    @(negedge clock); start = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    vec++; if (address !== 16'h068A) begin err++; $display("FAIL reset_address: got %h need 068a", address); end
    vec++; if (wr_en !== 1'b0) begin err++; $display("FAIL reset_wr_en: got %b need 0", wr_en); end
    vec++; if (data_out !== 16'h0) begin err++; $display("FAIL reset_data_out: got %h need 0", data_out); end
    vec++; if (done !== 1'b0) begin err++; $display("FAIL reset_done: got %b need 0", done); end
    vec++; if (index !== 16'h0) begin err++; $display("FAIL reset_index: got %h need 0", index); end
    vec++; if ({new_entry, table_full} !== 2'b00) begin
      err++; $display("FAIL reset_flags: got %b need 00", {new_entry, table_full});
    end
    @(negedge clock); nrst = 1'b1;
  endtask

  task automatic test_empty();
    int lat, n0;
    logic [15:0] ea [5];
    logic [15:0] ed [5];
    ea = '{16'h00C8, 16'h0148, 16'h01C8, 16'h0048, 16'h068A};
    ed = '{16'h0003, 16'h4000, 16'h0140, 16'h0007, 16'h0001};
    mem_clear();
    run_update(16'd7, 16'd3, 16'h4000, 16'h0140, lat, n0);
    vec++; if (lat !== 6) begin err++; $display("FAIL empty_latency: got %0d need 6", lat); end
    vec++; if (wn - n0 !== 5) begin err++; $display("FAIL empty_nwrites: got %0d need 5", wn - n0); end
    for (int k = 0; k < 5; k++) begin
      vec++;
      if (wa[n0 + k] !== ea[k] || wd[n0 + k] !== ed[k]) begin
        err++;
        $display("FAIL empty_write%0d: got %h=%h need %h=%h", k, wa[n0 + k], wd[n0 + k], ea[k], ed[k]);
      end
    end
    vec++; if ({index, new_entry, table_full} !== {16'd0, 2'b10}) begin
      err++; $display("FAIL empty_status: got %h/%b%b need 0000/10", index, new_entry, table_full);
    end
    drop_start();
    vec++; if (done !== 1'b0) begin err++; $display("FAIL empty_done_clear: got %b need 0", done); end
  endtask

  task automatic test_match();
    int lat, n0;
    mem_clear();
    mem_write(16'h068A, 16'd3);
    mem_write(16'h0048, 16'd5);
    mem_write(16'h004A, 16'd9);
    mem_write(16'h004C, 16'd12);
    run_update(16'd9, 16'h0011, 16'h8001, 16'hFFFF, lat, n0);
    vec++; if (lat !== 6) begin err++; $display("FAIL match_latency: got %0d need 6", lat); end
    vec++; if (wn - n0 !== 3) begin err++; $display("FAIL match_nwrites: got %0d need 3", wn - n0); end
    vec++; if ({wa[n0], wd[n0]} !== {16'h00CA, 16'h0011}) begin
      err++; $display("FAIL match_cid: got %h=%h need 00ca=0011", wa[n0], wd[n0]);
    end
    vec++; if ({wa[n0 + 1], wd[n0 + 1]} !== {16'h014A, 16'h8001}) begin
      err++; $display("FAIL match_bat: got %h=%h need 014a=8001", wa[n0 + 1], wd[n0 + 1]);
    end
    vec++; if ({wa[n0 + 2], wd[n0 + 2]} !== {16'h01CA, 16'hFFFF}) begin
      err++; $display("FAIL match_qv: got %h=%h need 01ca=ffff", wa[n0 + 2], wd[n0 + 2]);
    end
    vec++; if ({index, new_entry} !== {16'd1, 1'b0}) begin
      err++; $display("FAIL match_status: got %h/%b need 0001/0", index, new_entry);
    end
    drop_start();
    // Slot 0 boundary: fastest path
    run_update(16'd5, 16'h0022, 16'h0001, 16'h0002, lat, n0);
    vec++; if (lat !== 5) begin err++; $display("FAIL match0_latency: got %0d need 5", lat); end
    vec++; if ({index, wn - n0} !== {16'd0, 32'd3}) begin
      err++; $display("FAIL match0_status: got idx %h nwr %0d need 0000/3", index, wn - n0);
    end
    drop_start();
  endtask

  task automatic test_append();
    int lat, n0;
    run_update(16'd20, 16'h0002, 16'h7FFF, 16'h0020, lat, n0);
    vec++; if (lat !== 9) begin err++; $display("FAIL append_latency: got %0d need 9", lat); end
    vec++; if (wn - n0 !== 5) begin err++; $display("FAIL append_nwrites: got %0d need 5", wn - n0); end
    vec++; if ({wa[n0 + 3], wd[n0 + 3]} !== {16'h004E, 16'd20}) begin
      err++; $display("FAIL append_id: got %h=%h need 004e=0014", wa[n0 + 3], wd[n0 + 3]);
    end
    vec++; if (mem[16'h068A >> 1] !== 16'd4) begin
      err++; $display("FAIL append_count: got %h need 0004", mem[16'h068A >> 1]);
    end
    vec++; if ({mem[16'h00CE >> 1], mem[16'h014E >> 1], mem[16'h01CE >> 1]}
               !== {16'h0002, 16'h7FFF, 16'h0020}) begin
      err++; $display("FAIL append_fields: got %h %h %h need 0002 7fff 0020",
                      mem[16'h00CE >> 1], mem[16'h014E >> 1], mem[16'h01CE >> 1]);
    end
    vec++; if ({index, new_entry} !== {16'd3, 1'b1}) begin
      err++; $display("FAIL append_status: got %h/%b need 0003/1", index, new_entry);
    end
    drop_start();
  endtask

  task automatic test_full();
    int lat, n0;
    mem_clear();
    mem_write(16'h068A, 16'd64);
    for (int k = 0; k < 64; k++) mem_write(16'h0048 + 16'(2 * k), 16'(100 + k));
    run_update(16'd5, 16'h0001, 16'h0001, 16'h0001, lat, n0);
    vec++; if (lat !== 65) begin err++; $display("FAIL full_latency: got %0d need 65", lat); end
    vec++; if (wn - n0 !== 0) begin err++; $display("FAIL full_nwrites: got %0d need 0", wn - n0); end
    vec++; if ({table_full, new_entry} !== 2'b10) begin
      err++; $display("FAIL full_flags: got %b need 10", {table_full, new_entry});
    end
    drop_start();
  endtask

  task automatic test_reset_mid_write();
    int lat, n0, nr;
    mem_clear();
    @(negedge clock);
    pkt_src_id = 16'd4; pkt_cluster_id = 16'd1; pkt_battery = 16'h1234; pkt_qvalue = 16'h0005;
    start = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    vec++; if ({address, wr_en} !== {16'h0148, 1'b1}) begin
      err++; $display("FAIL midrst_in_wrbat: got %h/%b need 0148/1", address, wr_en);
    end
    @(negedge clock); nrst = 1'b0; start = 1'b0;
    @(posedge clock); #1;
    vec++; if ({wr_en, address, done} !== {1'b0, 16'h068A, 1'b0}) begin
      err++; $display("FAIL midrst_outputs: got %b/%h/%b need 0/068a/0", wr_en, address, done);
    end
    @(negedge clock); nrst = 1'b1;
    nr = wn;
    repeat (4) @(posedge clock);
    #1;
    vec++; if ({wn - nr, done} !== {32'd0, 1'b0}) begin
      err++; $display("FAIL midrst_idle: got nwr %0d done %b need 0/0", wn - nr, done);
    end
    run_update(16'd8, 16'h0009, 16'h0100, 16'h0200, lat, n0);
    vec++; if (lat !== 6) begin err++; $display("FAIL midrst_restart_latency: got %0d need 6", lat); end
    vec++; if ({mem[16'h0048 >> 1], mem[16'h068A >> 1]} !== {16'd8, 16'd1}) begin
      err++; $display("FAIL midrst_restart_mem: got %h %h need 0008 0001",
                      mem[16'h0048 >> 1], mem[16'h068A >> 1]);
    end
    drop_start();
  endtask

  task automatic test_back_to_back();
    int lat, n0;
    mem_clear();
    @(negedge clock);
    pkt_src_id = 16'd11; pkt_cluster_id = 16'd2; pkt_battery = 16'h0800; pkt_qvalue = 16'h0040;
    start = 1'b1;
    n0 = wn;
    @(posedge clock);
    @(negedge clock); start = 1'b0;
    @(negedge clock); start = 1'b1;
    lat = -1;
    for (int e = 2; e <= 100; e++) begin
      @(posedge clock); #1;
      if (done) begin lat = e; break; end
    end
    vec++; if (lat !== 6) begin err++; $display("FAIL b2b_latency: got %0d need 6", lat); end
    repeat (5) @(posedge clock);
    #1;
    vec++; if (done !== 1'b1) begin err++; $display("FAIL b2b_done_held: got %b need 1", done); end
    vec++; if ({wn - n0, mem[16'h068A >> 1]} !== {32'd5, 16'd1}) begin
      err++; $display("FAIL b2b_single_update: got nwr %0d count %h need 5/0001",
                      wn - n0, mem[16'h068A >> 1]);
    end
    drop_start();
    vec++; if (done !== 1'b0) begin err++; $display("FAIL b2b_done_clear: got %b need 0", done); end
    repeat (4) @(posedge clock);
    #1;
    vec++; if (wn - n0 !== 5) begin err++; $display("FAIL b2b_no_restart: got %0d need 5", wn - n0); end
  endtask

  initial begin
    start = 1'b0;
    pkt_src_id = 16'h0; pkt_cluster_id = 16'h0; pkt_battery = 16'h0; pkt_qvalue = 16'h0;
    test_reset();
    test_empty();
    test_match();
    test_append();
    test_full();
    test_reset_mid_write();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/neighbor_table_update.md
NEIGHBOR_TABLE_UPDATE -- requirements
Module: neighbor_table_update

Interface
REQ-001 Parameter MAX_NEIGHBORS, default 64: neighbor table capacity in entries.
REQ-002 Parameter ADDR_NCOUNT, default 16'h68A: byte address of the neighborCount word.
REQ-003 Port clock  input  1: rising-edge clock; reset nrst, synchronous, active-low.
REQ-004 Port nrst  input  1: synchronous active-low reset.
REQ-005 Port start  input  1: request to merge one received neighbor packet into the table.
REQ-006 Port pkt_src_id  input  16: sender node ID.
REQ-007 Port pkt_cluster_id  input  16: sender cluster ID.
REQ-008 Port pkt_battery  input  16: sender battery status, fixed-point 1.15.
REQ-009 Port pkt_qvalue  input  16: sender Q-value, fixed-point 11.5.
REQ-010 Port data_in  input  16: memory read data, valid the cycle after address changes.
REQ-011 Port address  output  16: memory byte address, registered.
REQ-012 Port wr_en  output  1: memory write strobe, registered.
REQ-013 Port data_out  output  16: memory write data, registered.
REQ-014 Port index  output  16: table slot written by the last update.
REQ-015 Port new_entry  output  1: last update appended a new neighbor.
REQ-016 Port table_full  output  1: last update was dropped because the table was full.
REQ-017 Port done  output  1: update complete; held until start is low.

Function
REQ-018 Table layout, entry i: neighborID 16'h48+2i; clusterID 16'hC8+2i; batteryStat 16'h148+2i; qValue 16'h1C8+2i.
REQ-019 States: IDLE, LD_CNT, SCAN, WR_CID, WR_BAT, WR_QV, WR_ID, WR_CNT, DONE.
REQ-020 IDLE on start=1: latch all pkt_* fields; address=ADDR_NCOUNT; clear index, new_entry and table_full; go LD_CNT.
REQ-021 LD_CNT: count=min(data_in, MAX_NEIGHBORS); if count=0, take the append path; otherwise address=16'h48, i=0, go SCAN.
REQ-022 SCAN match (data_in=src_id): index=i, new_entry=0, go to the write sequence; the first match wins.
REQ-023 SCAN miss: i=i+1 and address=16'h48+2i; when i reaches count, take the append path.
REQ-024 Append path, count<MAX_NEIGHBORS: index=count, new_entry=1, start the write sequence.
REQ-025 Append path, count>=MAX_NEIGHBORS: table_full=1; perform no writes; go DONE.
REQ-026 Write sequence: one word per cycle, wr_en=1 on each, in order clusterID, batteryStat, qValue.
REQ-027 If new_entry=1, the write sequence continues with neighborID=src_id, then ADDR_NCOUNT=count+1 (16-bit).
REQ-028 Entering DONE: wr_en=0, done=1; stay in DONE until start=0, then go IDLE with done=0.
REQ-029 start is ignored outside IDLE; latched pkt fields stay stable for the whole update.
REQ-030 Latency, measured in edges after the IDLE edge that samples start:
- Existing entry at slot k: done high after edge k+5.
- Append with count n: done high after edge n+6.
- Full table: done high after edge 65.
REQ-031 Fixed-point fields are stored verbatim: no scaling, no saturation.

Reset
REQ-032 nrst=0 at a clock edge: state=IDLE; address=ADDR_NCOUNT; wr_en=0; data_out=0.
REQ-033 nrst=0 also clears index, new_entry, table_full, done, i and count.
REQ-034 Reset mid-write drops wr_en at that edge; a partially written entry is not repaired.

Structure
REQ-035 Table base addresses, ADDR_NCOUNT, MAX_NEIGHBORS and the state encoding belong in the shared network-layer package.
REQ-036 The block is a single module with no sub-module.

Verification
REQ-037 Count=0, start with src 7, cid 3, bat 16'h4000, qv 16'h0140: writes C8=3, 148=4000, 1C8=0140, 48=7, 68A=1; index=0, new_entry=1, done after edge 6.
REQ-038 Count=3, IDs {5,9,12}, src 9: writes CA, 14A, 1CA only; new_entry=0, index=1, done after edge 6.
REQ-039 Count=3, src 20: appended at slot 3, 68A becomes 4, done after edge 9.
REQ-040 Count=64, src absent: table_full=1, no wr_en pulses, done after edge 65.
REQ-041 Assert nrst during WR_BAT: wr_en=0 next edge, FSM in IDLE; a new start completes normally.
REQ-042 Hold start high after done, pulse start while busy: exactly one update, done clears only after start falls.
